// File: rtl/regfile_pkg.sv
// Shared register-file definitions.
// Holds the register file geometry, the write-back requester indices and
// the one-hot register decode used to build pending-write masks.
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int NREGS  = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_MUL = 2;

    function automatic logic [NREGS-1:0] onehot_reg(input logic [REG_AW-1:0] addr);
        logic [NREGS-1:0] dec;
        dec       = '0;
        dec[addr] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (pointer -> 0)
//   req         - request vector, one bit per requester
//   advance     - allows the pointer to move past the granted index
//   grant       - one-hot grant, combinational from req and the pointer
//   anyGrant    - high when any grant bit is set
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         anyGrant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptrNext;
    logic [PW-1:0] idx;
    logic [PW:0]   sum;

    // Scan from ptr upward with wrap; the first requester found wins and
    // the pointer moves to the slot just after it.
    always_comb begin
        grant    = '0;
        anyGrant = 1'b0;
        ptrNext  = ptr;
        idx      = '0;
        sum      = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!anyGrant && req[idx]) begin
                anyGrant   = 1'b1;
                grant[idx] = 1'b1;
                ptrNext    = (idx == PW'(N-1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && anyGrant) begin
            ptr <= ptrNext;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Each requester owns a one-entry holding buffer; buffered writes are
// picked round-robin and presented on a registered write port.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   req_valid   - per-requester write request
//   req_rd      - per-requester destination register, slice [i*AW +: AW]
//   req_data    - per-requester write data, slice [i*DW +: DW]
//   req_ready   - per-requester accept
//   wr_en       - register file write enable
//   wr_addr     - register file write address
//   wr_data     - register file write data
//   pend_mask   - registers with a write buffered or on the output stage
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = REG_DW,
    parameter int AW   = REG_AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic [2**AW-1:0]     pend_mask
);

    logic [NREQ-1:0] bufValid;
    logic [AW-1:0]   bufRd   [NREQ];
    logic [DW-1:0]   bufData [NREQ];
    logic [NREQ-1:0] grant;
    logic            anyGrant;
    logic [NREQ-1:0] accept;
    logic [AW-1:0]   selRd;
    logic [DW-1:0]   selData;

    rr_arbiter #(.N(NREQ)) arb (
        .clk      (clk),
        .reset    (reset),
        .req      (bufValid),
        .advance  (1'b1),
        .grant    (grant),
        .anyGrant (anyGrant)
    );

    // A draining buffer may refill on the same edge.
    assign req_ready = {NREQ{~reset}} & (~bufValid | grant);
    assign accept    = req_valid & req_ready;

    // ---- Holding buffers ----
    // Writes to r0 are acknowledged but leave the buffer empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bufValid <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i]) begin
                    bufValid[i] <= (req_rd[i*AW +: AW] != '0);
                end else if (grant[i]) begin
                    bufValid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                bufRd[i]   <= req_rd[i*AW +: AW];
                bufData[i] <= req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        selRd   = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                selRd   = selRd | bufRd[i];
                selData = selData | bufData[i];
            end
        end
    end

    // ---- Output stage ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= |bufValid;
            if (anyGrant) begin
                wr_addr <= selRd;
                wr_data <= selData;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bufValid[i]) begin
                pend_mask = pend_mask | onehot_reg(bufRd[i]);
            end
        end
        if (wr_en) begin
            pend_mask = pend_mask | onehot_reg(wr_addr);
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_rd;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [2**AW-1:0]  pend_mask;

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nBad    = 0;

    // Reference model: holding buffers as arrays, round-robin pointer as an
    // integer, and the write port contents.
    bit             mValid [NREQ];
    logic [AW-1:0]  mRd    [NREQ];
    logic [DW-1:0]  mData  [NREQ];
    int             mPtr;
    bit             mWrEn;
    logic [AW-1:0]  mWrAddr;
    logic [DW-1:0]  mWrData;
    int             wlog[$];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int modelGrant();
        for (int k = 0; k < NREQ; k++) begin
            if (mValid[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] modelPend();
        logic [31:0] p = '0;
        for (int i = 0; i < NREQ; i++) if (mValid[i]) p[mRd[i]] = 1'b1;
        if (mWrEn) p[mWrAddr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NREQ; i++) begin
            mValid[i] = 0;
            mRd[i]    = '0;
            mData[i]  = '0;
        end
        mPtr    = 0;
        mWrEn   = 0;
        mWrAddr = '0;
        mWrData = '0;
    endtask

    task automatic modelEdge();
        int g;
        if (reset) begin
            modelReset();
            return;
        end
        g = modelGrant();
        mWrEn = 0;
        for (int i = 0; i < NREQ; i++) if (mValid[i]) mWrEn = 1;
        if (g >= 0) begin
            mWrAddr = mRd[g];
            mWrData = mData[g];
            mPtr    = (g + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
            automatic logic [AW-1:0] rd = req_rd[i*AW +: AW];
            if (req_valid[i] && (!mValid[i] || g == i)) begin
                mValid[i] = (rd != 0);
                mRd[i]    = rd;
                mData[i]  = req_data[i*DW +: DW];
            end else if (g == i) begin
                mValid[i] = 0;
            end
        end
    endtask

    task automatic checkOutputs();
        int g = modelGrant();
        for (int i = 0; i < NREQ; i++) begin
            checkVal($sformatf("ready%0d", i), 64'(req_ready[i]),
                     64'(!reset && (!mValid[i] || g == i)));
        end
        checkVal("wr_en", 64'(wr_en), 64'(mWrEn));
        checkVal("wr_addr", 64'(wr_addr), 64'(mWrAddr));
        checkVal("wr_data", 64'(wr_data), 64'(mWrData));
        checkVal("pend_mask", 64'(pend_mask), 64'(modelPend()));
        if (wr_en) wlog.push_back(int'(wr_addr));
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutputs();
    endtask

    task automatic setReq(input int i, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_rd[i*AW +: AW]   = rd;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic clearReqs();
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearReqs();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int readyCnt [NREQ];
        reset = 1'b1;
        clearReqs();
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutputs();
        checkVal("rst_ready", 64'(req_ready), 64'(0));
        checkVal("rst_pend", 64'(pend_mask), 64'(0));
        reset = 1'b0;

        // Single write from requester 0: rd=5.
        setReq(0, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        setReq(0, 1'b0, 5'd0, 32'h0);
        checkVal("t1_pend_buf", 64'(pend_mask[5]), 64'(1));
        checkVal("t1_wr_en_early", 64'(wr_en), 64'(0));
        cycle();
        checkVal("t1_wr_en", 64'(wr_en), 64'(1));
        checkVal("t1_wr_addr", 64'(wr_addr), 64'(5));
        checkVal("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
        checkVal("t1_pend_out", 64'(pend_mask[5]), 64'(1));
        cycle();
        checkVal("t1_pend_clear", 64'(pend_mask[5]), 64'(0));
        checkVal("t1_wr_en_done", 64'(wr_en), 64'(0));

        // Pointer now sits at 1: requesters 0 and 2 together, 2 goes first.
        wlog.delete();
        setReq(0, 1'b1, 5'd12, 32'hAAAA0000);
        setReq(2, 1'b1, 5'd14, 32'hCCCC0000);
        cycle();
        clearReqs();
        repeat (4) cycle();
        checkVal("ptr_nwrites", 64'(wlog.size()), 64'(2));
        if (wlog.size() == 2) begin
            checkVal("ptr_first", 64'(wlog[0]), 64'(14));
            checkVal("ptr_second", 64'(wlog[1]), 64'(12));
        end

        // Full contention, rd 1,2,3 held continuously.
        doReset();
        wlog.delete();
        for (int i = 0; i < NREQ; i++) readyCnt[i] = 0;
        setReq(0, 1'b1, 5'd1, 32'h11);
        setReq(1, 1'b1, 5'd2, 32'h22);
        setReq(2, 1'b1, 5'd3, 32'h33);
        for (int c = 0; c < 9; c++) begin
            cycle();
            for (int i = 0; i < NREQ; i++) readyCnt[i] += int'(req_ready[i]);
        end
        checkVal("rr_nwrites", 64'(wlog.size()), 64'(8));
        for (int k = 0; k < 6 && k < wlog.size(); k++) begin
            checkVal($sformatf("rr_order%0d", k), 64'(wlog[k]), 64'((k % 3) + 1));
        end
        for (int i = 0; i < NREQ; i++) begin
            checkVal($sformatf("rr_ready_cnt%0d", i), 64'(readyCnt[i]), 64'(3));
        end
        clearReqs();
        repeat (4) cycle();

        // r0 write is acknowledged and discarded.
        setReq(1, 1'b1, 5'd0, 32'h1234);
        checkVal("r0_ready", 64'(req_ready[1]), 64'(1));
        cycle();
        clearReqs();
        for (int c = 0; c < 3; c++) begin
            checkVal("r0_wr_en", 64'(wr_en), 64'(0));
            checkVal("r0_pend", 64'(pend_mask), 64'(0));
            cycle();
        end

        // Uncontended stream from requester 2.
        wlog.delete();
        for (int k = 0; k < 3; k++) begin
            setReq(2, 1'b1, 5'(7 + k), 32'(32'h700 + k));
            checkVal("stream_ready", 64'(req_ready[2]), 64'(1));
            cycle();
        end
        clearReqs();
        repeat (3) cycle();
        checkVal("stream_nwrites", 64'(wlog.size()), 64'(3));
        for (int k = 0; k < 3 && k < wlog.size(); k++) begin
            checkVal($sformatf("stream_order%0d", k), 64'(wlog[k]), 64'(7 + k));
        end

        // Asynchronous reset with rd=10 on the output stage and rd=11 buffered.
        setReq(0, 1'b1, 5'd10, 32'hA10);
        cycle();
        setReq(0, 1'b1, 5'd11, 32'hA11);
        cycle();
        clearReqs();
        checkVal("ar_pre_wr_addr", 64'(wr_addr), 64'(10));
        checkVal("ar_pre_pend", 64'(pend_mask), 64'(32'h0C00));
        #2;
        reset = 1'b1;
        #1;
        checkVal("ar_wr_en", 64'(wr_en), 64'(0));
        checkVal("ar_wr_addr", 64'(wr_addr), 64'(0));
        checkVal("ar_wr_data", 64'(wr_data), 64'(0));
        checkVal("ar_pend", 64'(pend_mask), 64'(0));
        checkVal("ar_ready", 64'(req_ready), 64'(0));
        modelReset();
        cycle();
        reset = 1'b0;
        wlog.delete();
        repeat (4) cycle();
        checkVal("ar_no_writes", 64'(wlog.size()), 64'(0));

        // Randomised traffic against the model.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                setReq(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom);
            end
            if (c == 150) reset = 1'b1;
            if (c == 152) reset = 1'b0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
